riscv_alu_div_iter: RTL

RISCV_ALU_DIV_ITER -- requirements
Module: riscv_alu_div_iter

---
 rtl/riscv_alu_div_iter_if.sv | 32 +++
 rtl/riscv_alu_div_iter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/riscv_alu_div_iter_if.sv
// ============================================================================
// Module      : riscv_alu_div_iter_if
// Description : Request/result handshake bundle for the iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface riscv_alu_div_iter_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] opa_i;
    logic [WIDTH-1:0] opb_i;
    logic [1:0]       opcode_i;
    logic             kill_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] result_o;

    modport slave (
        input  valid_i, opa_i, opb_i, opcode_i, kill_i, ready_i,
        output ready_o, valid_o, result_o
    );

    modport master (
        output valid_i, opa_i, opb_i, opcode_i, kill_i, ready_i,
        input  ready_o, valid_o, result_o
    );
endinterface

`default_nettype wire

// File: rtl/riscv_alu_div_iter.sv
// ============================================================================
// Module      : riscv_alu_div_iter
// Description : Radix-2 restoring divider (udiv/div/urem/rem), one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_alu_div_iter #(
    parameter int WIDTH = 32
) (
    input  wire logic            clk,
    input  wire logic            rst,
    riscv_alu_div_iter_if.slave  bus
);

    localparam int               c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [1:0]       c_ST_IDLE   = 2'd0;
    localparam logic [1:0]       c_ST_DIVIDE = 2'd1;
    localparam logic [1:0]       c_ST_FINISH = 2'd2;
    localparam logic [WIDTH-1:0] c_MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_ALL_ONES  = {WIDTH{1'b1}};

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH:0]     r_rem;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_sel_rem;
    logic [WIDTH-1:0]   r_result;

    logic               w_accept;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic               w_div_zero;
    logic               w_overflow;
    logic               w_special;
    logic [WIDTH-1:0]   w_special_res;
    logic [WIDTH+1:0]   w_rem_shift;
    logic [WIDTH+1:0]   w_diff;
    logic               w_qbit;
    logic [WIDTH:0]     w_rem_next;
    logic [WIDTH-1:0]   w_quot_next;
    logic [WIDTH-1:0]   w_q_final;
    logic [WIDTH-1:0]   w_r_final;
    logic               w_div_done;
    logic               w_ready;
    logic               w_valid;

    assign w_accept   = bus.valid_i && (r_state == c_ST_IDLE) && !bus.kill_i;
    assign w_signed   = bus.opcode_i[0];
    assign w_a_neg    = w_signed && bus.opa_i[WIDTH-1];
    assign w_b_neg    = w_signed && bus.opb_i[WIDTH-1];
    assign w_a_abs    = w_a_neg ? -bus.opa_i : bus.opa_i;
    assign w_b_abs    = w_b_neg ? -bus.opb_i : bus.opb_i;
    assign w_div_zero = (bus.opb_i == '0);
    assign w_overflow = w_signed && (bus.opa_i == c_MOST_NEG) && (bus.opb_i == c_ALL_ONES);
    assign w_special  = w_div_zero || w_overflow;

    // Corner cases bypass the iteration: divide-by-zero wins over overflow
    // (the overflow divisor is non-zero, so they never coincide anyway).
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = bus.opcode_i[1] ? bus.opa_i : c_ALL_ONES;
        end else begin
            w_special_res = bus.opcode_i[1] ? '0 : bus.opa_i;
        end
    end

    // The top bit of r_rem is always zero after a step, so bit WIDTH+1 of the
    // difference is a clean borrow flag.
    assign w_rem_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_diff      = w_rem_shift - {2'b00, r_divisor};
    assign w_qbit      = ~w_diff[WIDTH+1];
    assign w_rem_next  = w_qbit ? w_diff[WIDTH:0] : w_rem_shift[WIDTH:0];
    assign w_quot_next = {r_quot[WIDTH-2:0], w_qbit};
    assign w_q_final   = r_neg_q ? -w_quot_next : w_quot_next;
    assign w_r_final   = r_neg_r ? -w_rem_next[WIDTH-1:0] : w_rem_next[WIDTH-1:0];
    assign w_div_done  = (r_state == c_ST_DIVIDE) && (r_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_ready = 1'b1;
                if (w_accept) begin
                    w_state_next = w_special ? c_ST_FINISH : c_ST_DIVIDE;
                end
            end
            c_ST_DIVIDE: begin
                if (r_count == '0) begin
                    w_state_next = c_ST_FINISH;
                end
            end
            c_ST_FINISH: begin
                w_valid = 1'b1;
                if (bus.ready_i) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
        if (bus.kill_i) begin
            w_state_next = c_ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_sel_rem <= 1'b0;
            r_result  <= '0;
        end else if (bus.kill_i) begin
            r_count  <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_count   <= c_CNT_W'(WIDTH - 1);
            r_quot    <= w_a_abs;
            r_divisor <= w_b_abs;
            r_rem     <= '0;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_sel_rem <= bus.opcode_i[1];
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if (r_state == c_ST_DIVIDE) begin
            r_quot <= w_quot_next;
            r_rem  <= w_rem_next;
            if (w_div_done) begin
                r_result <= r_sel_rem ? w_r_final : w_q_final;
            end else begin
                r_count <= r_count - 1'b1;
            end
        end else if ((r_state == c_ST_FINISH) && bus.ready_i) begin
            r_result <= '0;
        end
    end

    assign bus.ready_o  = w_ready;
    assign bus.valid_o  = w_valid;
    assign bus.result_o = r_result;

endmodule

`default_nettype wire
